// File: rtl/mem_stage_unit.sv
// Memory pipeline stage: byte-addressed big-endian data RAM with byte/half/word
// access, configurable load latency, and fault reporting for bad requests.
module mem_stage_unit #(
   parameter int unsigned ADDR_BITS = 8,
   parameter int unsigned RD_WAIT   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        done,
   output logic        fault
);

   localparam int unsigned DEPTH = 32'd1 << ADDR_BITS;
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] WAIT_INIT = (RD_WAIT == 0) ? '0 : CNT_W'(RD_WAIT - 1);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t               state, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] addr_q;
   logic [1:0]           size_q;
   logic                 sext_q;
   logic                 busy_d, done_d, fault_d;
   logic [31:0]          rdata_d;

   logic [7:0]           mem [DEPTH];

   logic                 accept_c, req_fault_c, store_c;
   logic [ADDR_BITS-1:0] a0_c, a1_c, a2_c, a3_c;
   logic [1:0]           acc_size_c;
   logic                 acc_sext_c;
   logic [7:0]           b0_c, b1_c, b2_c, b3_c;
   logic [31:0]          load_val_c;
   logic                 unused_addr_c;

   assign unused_addr_c = ^addr[31:ADDR_BITS];

   // Request qualification; only meaningful while IDLE.
   assign accept_c    = (state == IDLE) && in_valid && (mem_read || mem_write);
   assign req_fault_c = (size == SZ_ILL)
                     || ((size == SZ_HALF) && addr[0])
                     || ((size == SZ_WORD) && (addr[1:0] != 2'b00))
                     || (mem_read && mem_write);
   assign store_c     = !reset && accept_c && mem_write && !req_fault_c;

   // In IDLE the live request is the access; later the captured fields are.
   assign a0_c       = (state == IDLE) ? addr[ADDR_BITS-1:0] : addr_q;
   assign acc_size_c = (state == IDLE) ? size : size_q;
   assign acc_sext_c = (state == IDLE) ? sign_ext : sext_q;
   assign a1_c       = a0_c + ADDR_BITS'(1);
   assign a2_c       = a0_c + ADDR_BITS'(2);
   assign a3_c       = a0_c + ADDR_BITS'(3);
   assign b0_c       = mem[a0_c];
   assign b1_c       = mem[a1_c];
   assign b2_c       = mem[a2_c];
   assign b3_c       = mem[a3_c];

   always_comb begin
      load_val_c = '0;
      case (acc_size_c)
         SZ_BYTE: load_val_c = {{24{acc_sext_c & b0_c[7]}}, b0_c};
         SZ_HALF: load_val_c = {{16{acc_sext_c & b0_c[7]}}, b0_c, b1_c};
         default: load_val_c = {b0_c, b1_c, b2_c, b3_c};
      endcase
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d = state;
      cnt_d   = cnt_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      fault_d = 1'b0;
      rdata_d = rdata;
      case (state)
         IDLE: begin
            if (accept_c) begin
               if (req_fault_c) begin
                  state_d = RESP;
                  done_d  = 1'b1;
                  fault_d = 1'b1;
               end else if (mem_write) begin
                  state_d = RESP;
                  done_d  = 1'b1;
               end else if (RD_WAIT == 0) begin
                  state_d = RESP;
                  done_d  = 1'b1;
                  rdata_d = load_val_c;
               end else begin
                  state_d = WAIT;
                  busy_d  = 1'b1;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
               done_d  = 1'b1;
               rdata_d = load_val_c;
            end else begin
               cnt_d  = cnt_q - CNT_W'(1);
               busy_d = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt_q  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         fault  <= 1'b0;
         rdata  <= '0;
         addr_q <= '0;
         size_q <= '0;
         sext_q <= 1'b0;
      end else begin
         state <= state_d;
         cnt_q <= cnt_d;
         busy  <= busy_d;
         done  <= done_d;
         fault <= fault_d;
         rdata <= rdata_d;
         if (accept_c) begin
            addr_q <= addr[ADDR_BITS-1:0];
            size_q <= size;
            sext_q <= sign_ext;
         end
      end
   end

   // RAM is not reset; stores commit on the accept edge.
   always_ff @(posedge clk) begin
      if (store_c) begin
         case (size)
            SZ_BYTE: mem[a0_c] <= wdata[7:0];
            SZ_HALF: begin
               mem[a0_c] <= wdata[15:8];
               mem[a1_c] <= wdata[7:0];
            end
            default: begin
               mem[a0_c] <= wdata[31:24];
               mem[a1_c] <= wdata[23:16];
               mem[a2_c] <= wdata[15:8];
               mem[a3_c] <= wdata[7:0];
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Bench for mem_stage_unit: timeline-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_stage_unit;

   localparam int unsigned ADDR_BITS = 8;
   localparam int unsigned RD_WAIT   = 1;
   localparam int unsigned DEPTH     = 256;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   logic        clk = 1'b0;
   logic        reset, in_valid, mem_read, mem_write, sign_ext;
   logic [1:0]  size;
   logic [31:0] addr, wdata, rdata;
   logic        busy, done, fault;

   always #5 clk = ~clk;

   mem_stage_unit #(.ADDR_BITS(ADDR_BITS), .RD_WAIT(RD_WAIT)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .mem_read(mem_read),
      .mem_write(mem_write), .size(size), .sign_ext(sign_ext), .addr(addr),
      .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .fault(fault)
   );

   int          checks, errors;
   longint      e;
   logic [7:0]  m [DEPTH];
   longint      ready_at, done_at, busy_from, busy_to;
   logic        pend_fault, pend_load;
   logic [31:0] pend_val;
   logic        exp_busy, exp_done, exp_fault;
   logic [31:0] exp_rdata;
   logic        obs_busy, obs_done, obs_fault;
   logic [31:0] obs_rdata;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h (edge %0d)", name, got, want, e);
      end
   endtask

   function automatic logic mfault(input logic r, w, input logic [1:0] sz, input logic [31:0] a);
      return (sz == SZ_ILL) || (sz == SZ_HALF && a[0]) || (sz == SZ_WORD && a[1:0] != 2'b00) || (r && w);
   endfunction

   function automatic logic [31:0] mload(input logic [1:0] sz, input logic sx, input logic [31:0] a);
      int unsigned b;
      logic [31:0] v;
      b = a % DEPTH;
      if (sz == SZ_BYTE) begin
         v = {24'h0, m[b]};
         if (sx && m[b][7]) v = v | 32'hFFFF_FF00;
      end else if (sz == SZ_HALF) begin
         v = {16'h0, m[b], m[(b + 1) % DEPTH]};
         if (sx && m[b][7]) v = v | 32'hFFFF_0000;
      end else begin
         v = {m[b], m[(b + 1) % DEPTH], m[(b + 2) % DEPTH], m[(b + 3) % DEPTH]};
      end
      return v;
   endfunction

   task automatic mstore(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      int unsigned b;
      b = a % DEPTH;
      if (sz == SZ_BYTE) m[b] = wd[7:0];
      else if (sz == SZ_HALF) begin
         m[b] = wd[15:8];
         m[(b + 1) % DEPTH] = wd[7:0];
      end else begin
         m[b] = wd[31:24];
         m[(b + 1) % DEPTH] = wd[23:16];
         m[(b + 2) % DEPTH] = wd[15:8];
         m[(b + 3) % DEPTH] = wd[7:0];
      end
   endtask

   // One clock: drive inputs, predict outputs after the edge, then compare.
   task automatic step(input logic rst, iv, r, w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, wd);
      @(negedge clk);
      reset = rst; in_valid = iv; mem_read = r; mem_write = w;
      size = sz; sign_ext = sx; addr = a; wdata = wd;
      if (rst) begin
         exp_busy = 0; exp_done = 0; exp_fault = 0; exp_rdata = '0;
         ready_at = e + 1; done_at = -1; busy_from = 1; busy_to = 0;
      end else begin
         if (e >= ready_at && iv && (r || w)) begin
            pend_fault = mfault(r, w, sz, a);
            pend_load  = 0;
            busy_from  = 1; busy_to = 0;
            if (pend_fault || w) begin
               if (!pend_fault) mstore(sz, a, wd);
               done_at  = e;
               ready_at = e + 2;
            end else begin
               pend_load = 1;
               pend_val  = mload(sz, sx, a);
               done_at   = e + longint'(RD_WAIT);
               busy_from = e;
               busy_to   = e + longint'(RD_WAIT) - 1;
               ready_at  = e + longint'(RD_WAIT) + 2;
            end
         end
         exp_busy  = (e >= busy_from) && (e <= busy_to);
         exp_done  = (e == done_at);
         exp_fault = exp_done && pend_fault;
         if (exp_done && pend_load) exp_rdata = pend_val;
      end
      @(posedge clk);
      #1;
      chk("rdata", rdata, exp_rdata);
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("fault", 32'(fault), 32'(exp_fault));
      obs_busy = busy; obs_done = done; obs_fault = fault; obs_rdata = rdata;
      e++;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
   endtask

   // Issue one request and run until its done pulse; junk requests fill the wait.
   task automatic req(input logic r, w, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, wd, input logic junk,
                      output logic [31:0] rd, output logic f, output int bc);
      int n;
      step(1'b0, 1'b1, r, w, sz, sx, a, wd);
      bc = obs_busy ? 1 : 0;
      n = 0;
      while (!obs_done && n < 20) begin
         step(1'b0, junk, 1'b0, junk, SZ_WORD, 1'b0, 32'h0000_00FC, 32'h0);
         if (obs_busy) bc++;
         n++;
      end
      if (!obs_done) chk("req_timeout", 32'(obs_done), 32'd1);
      rd = obs_rdata;
      f  = obs_fault;
      idle();
   endtask

   initial begin
      logic [31:0] rd, a;
      logic        f, r, w, rst, iv;
      logic [1:0]  sz;
      int          bc, kind;
      checks = 0; errors = 0; e = 0;
      reset = 1; in_valid = 0; mem_read = 0; mem_write = 0;
      size = 0; sign_ext = 0; addr = 0; wdata = 0;
      pend_fault = 0; pend_load = 0; pend_val = 0;

      step(1'b1, 1'b0, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h0, 32'h1234_5678);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);

      for (int i = 0; i < int'(DEPTH); i += 4)
         req(1'b0, 1'b1, SZ_WORD, 1'b0, 32'(i), $urandom, 1'b0, rd, f, bc);

      req(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h1122_3344, 1'b0, rd, f, bc);
      chk("store_busy", 32'(bc), 32'd0);
      req(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, 1'b0, rd, f, bc);
      chk("ldb_rdata", rd, 32'h0000_0022);
      chk("ldb_busy_cycles", 32'(bc), 32'd1);
      req(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 1'b0, rd, f, bc);
      chk("ldh_rdata", rd, 32'h0000_3344);

      req(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h20, 32'hFFFF_FF80, 1'b0, rd, f, bc);
      req(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h20, 32'h0, 1'b0, rd, f, bc);
      chk("ldb_sext", rd, 32'hFFFF_FF80);
      req(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h20, 32'h0, 1'b0, rd, f, bc);
      chk("ldb_zext", rd, 32'h0000_0080);

      req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h02, 32'h0, 1'b0, rd, f, bc);
      chk("misw_fault", 32'(f), 32'd1);
      chk("misw_busy", 32'(bc), 32'd0);
      chk("misw_rdata", rd, 32'h0000_0080);
      req(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h03, 32'h0, 1'b0, rd, f, bc);
      chk("mish_fault", 32'(f), 32'd1);
      req(1'b1, 1'b0, SZ_ILL, 1'b0, 32'h00, 32'h0, 1'b0, rd, f, bc);
      chk("ill_fault", 32'(f), 32'd1);

      req(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h04, 32'hCAFE_F00D, 1'b0, rd, f, bc);
      req(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h04, 32'h0BAD_0BAD, 1'b0, rd, f, bc);
      chk("rw_fault", 32'(f), 32'd1);
      req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h04, 32'h0, 1'b0, rd, f, bc);
      chk("rw_ram_kept", rd, 32'hCAFE_F00D);
      chk("ld_ok_fault", 32'(f), 32'd0);

      req(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h30, 32'hA5A5_5A5A, 1'b0, rd, f, bc);
      step(1'b0, 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0);
      chk("midload_busy", 32'(busy), 32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_rdata", rdata, 32'h0);
      for (int i = 0; i < 3; i++) begin
         idle();
         chk("postrst_done", 32'(done), 32'd0);
      end
      req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, 1'b0, rd, f, bc);
      chk("postrst_ram", rd, 32'hA5A5_5A5A);

      req(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h1FC, 32'hDEAD_BEEF, 1'b0, rd, f, bc);
      req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'hFC, 32'h0, 1'b1, rd, f, bc);
      chk("alias_load", rd, 32'hDEAD_BEEF);
      req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'hFC, 32'h0, 1'b0, rd, f, bc);
      chk("junk_ignored", rd, 32'hDEAD_BEEF);

      for (int i = 0; i < 3000; i++) begin
         kind = int'($urandom_range(0, 9));
         rst  = ($urandom_range(0, 99) == 0);
         iv   = ($urandom_range(0, 3) != 0);
         r    = (kind <= 3) || (kind == 8);
         w    = (kind >= 4) && (kind <= 8);
         sz   = ($urandom_range(0, 11) == 0) ? SZ_ILL : 2'($urandom_range(0, 2));
         a    = $urandom;
         if ($urandom_range(0, 4) != 0) begin
            if (sz == SZ_WORD) a[1:0] = 2'b00;
            else if (sz == SZ_HALF) a[0] = 1'b0;
         end
         step(rst, iv, r, w, sz, 1'($urandom_range(0, 1)), a, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_stage_unit.md
MEM_STAGE_UNIT -- requirements
Module: mem_stage_unit

Interface
REQ-001 Parameter ADDR_BITS, default 8; byte-address width of the internal data RAM (2^ADDR_BITS bytes).
REQ-002 Parameter RD_WAIT, default 1; number of busy cycles inserted before a load response (0..15).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset: synchronous, active-high; clock: clk.
REQ-005 in_valid  input  1  request strobe from the EX/MEM pipeline register.
REQ-006 mem_read  input  1  request is a load.
REQ-007 mem_write  input  1  request is a store.
REQ-008 size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 sign_ext  input  1  sign-extend byte/halfword loads when 1, zero-extend when 0.
REQ-010 addr  input  32  byte address; only addr[ADDR_BITS-1:0] used.
REQ-011 wdata  input  32  store data, right-justified.
REQ-012 rdata  output  32  load result, registered.
REQ-013 busy  output  1  registered; high while a load is waiting, for pipeline stall.
REQ-014 done  output  1  registered; one-cycle completion pulse for every accepted request.
REQ-015 fault  output  1  registered; qualifies done: request was misaligned, illegal size, or both read and write.

Function
REQ-016 FSM states IDLE, WAIT, RESP; requests accepted only in IDLE; in_valid ignored in WAIT and RESP.
REQ-017 Accept: IDLE and in_valid and (mem_read or mem_write); in_valid with neither set is a no-op, FSM stays IDLE.
REQ-018 Fault conditions: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=00; mem_read and mem_write both 1.
REQ-019 Faulting request: no RAM access, rdata unchanged, next state RESP with fault=1.
REQ-020 Store: RAM written on the accept edge; next state RESP; busy never asserted.
REQ-021 Load with RD_WAIT>0: next state WAIT, busy=1 for exactly RD_WAIT cycles, then RESP.
REQ-022 Load with RD_WAIT=0: next state RESP directly, busy never asserted.
REQ-023 RESP: done=1 (and fault as determined) for exactly one cycle; for loads rdata updated in the same cycle; then IDLE.
REQ-024 Minimum spacing: one store per 2 cycles, one load per RD_WAIT+2 cycles.
REQ-025 Big-endian: word at address a = {M[a],M[a+1],M[a+2],M[a+3]}; halfword = {M[a],M[a+1]}.
REQ-026 Store byte writes wdata[7:0]; halfword writes wdata[15:0]; word writes wdata[31:0]; other bytes untouched.
REQ-027 Load byte/halfword right-justified in rdata, upper bits sign- or zero-extended per sign_ext; sign_ext ignored for words.
REQ-028 Address arithmetic modulo 2^ADDR_BITS; upper addr bits ignored, so 0x100 aliases 0x000 at default.
REQ-029 Request fields captured at accept; input changes afterward do not affect the response.
REQ-030 rdata holds its value until the next successful load response.

Reset
REQ-031 On reset: state IDLE, rdata=0, busy=0, done=0, fault=0, wait counter 0.
REQ-032 Reset mid-load abandons it: no done pulse afterward; a store committed before reset remains in RAM.
REQ-033 RAM contents are not cleared by reset.
REQ-034 Reset has priority over a request presented on the same edge; that request is dropped.

Verification
REQ-035 Store word 0x11223344 at 0x10, load byte 0x11 sign_ext=0 -> busy 1 cycle, done with rdata=0x00000022.
REQ-036 Store byte 0x80 at 0x20, load byte sign_ext=1 -> rdata=0xFFFFFF80; sign_ext=0 -> 0x00000080.
REQ-037 Load word at 0x02 -> done=1, fault=1, busy never high, rdata unchanged; halfword at 0x03 and size=11 also fault.
REQ-038 mem_read=mem_write=1 at 0x04 -> fault pulse, RAM at 0x04..0x07 unchanged on later load.
REQ-039 Reset asserted during WAIT of a load -> no done, outputs 0; earlier store data still readable.
REQ-040 Store word at 0x1FC with ADDR_BITS=8 then load word at 0xFC -> same data (alias); back-to-back in_valid during WAIT ignored.
